// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
//
// Purpose
//   Exhaustively drives a combinational function block with N_IN inputs. Every
//   input vector from 0 to 2^N_IN-1 is applied in ascending order and held for
//   SETTLE+1 cycles. On the last of those cycles the block output f_in is
//   captured into a truth-table register and compared against a golden table.
//   A pass/fail summary is left on the outputs after each run.
//
// Ports
//   clk          in   1         rising-edge clock, the only clock
//   rst          in   1         synchronous reset, active-high
//   start        in   1         begin a run; accepted only while idle
//   expected     in   2^N_IN    golden table, bit i = expected f for vector i,
//                               latched when start is accepted
//   f_in         in   1         output of the function block under test
//   vec_out      out  N_IN      function inputs, vec_out[N_IN-1]=a ... [0]=d
//   busy         out  1         high from the start-accept edge until done
//   done         out  1         one-cycle pulse when the run completes
//   table_out    out  2^N_IN    captured table, bit i = f_in seen for vector i
//   err_count    out  N_IN+1    number of vectors where f_in != expected bit
//   match        out  1         err_count==0; valid with done, held until the
//                               next accepted start
//   first_fail   out  N_IN      lowest failing vector index, 0 if none
//   fail_seen    out  1         at least one mismatch in the current run
//   state_dbg_o  out  2         current FSM state (IDLE=0 WAIT=1 SAMPLE=2
//                               FINISH=3) for checkers and debug
//
// Handshake
//   start is a level sampled on the rising edge: a start seen in IDLE is
//   accepted on that edge, starts elsewhere are ignored. done is a single-cycle
//   pulse with no acknowledge; the summary outputs stay valid until the next
//   accepted start, so a consumer may read them any time after done.
// -----------------------------------------------------------------------------
module truth_table_sequencer #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [(1<<N_IN)-1:0]   expected,
   input  logic                   f_in,
   output logic [N_IN-1:0]        vec_out,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic [N_IN:0]          err_count,
   output logic                   match,
   output logic [N_IN-1:0]        first_fail,
   output logic                   fail_seen,
   output logic [1:0]             state_dbg_o
);

   localparam int TBL_W = 1 << N_IN;

   // The wait counter only has to reach SETTLE-1; keep at least one bit so
   // SETTLE=1 still yields a legal vector.
   localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]   VEC_LAST  = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [N_IN-1:0]     vec_q, vec_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [TBL_W-1:0]    exp_q, exp_d;
   logic [TBL_W-1:0]    table_q, table_d;
   logic [N_IN:0]       err_q, err_d;
   logic                match_q, match_d;
   logic [N_IN-1:0]     ffail_q, ffail_d;
   logic                fseen_q, fseen_d;
   logic                busy_q, busy_d;

   // Mismatch between the block output and the latched golden bit for the
   // vector currently applied. Only meaningful in ST_SAMPLE.
   logic                sample_mismatch;

   assign sample_mismatch = (f_in != exp_q[vec_q]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         wait_q  <= '0;
         exp_q   <= '0;
         table_q <= '0;
         err_q   <= '0;
         match_q <= 1'b0;
         ffail_q <= '0;
         fseen_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         wait_q  <= wait_d;
         exp_q   <= exp_d;
         table_q <= table_d;
         err_q   <= err_d;
         match_q <= match_d;
         ffail_q <= ffail_d;
         fseen_q <= fseen_d;
         busy_q  <= busy_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath updates
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      wait_d  = wait_q;
      exp_d   = exp_q;
      table_d = table_q;
      err_d   = err_q;
      match_d = match_q;
      ffail_d = ffail_q;
      fseen_d = fseen_q;
      busy_d  = busy_q;

      unique case (state_q)
         ST_IDLE: begin
            // Everything from the previous run is held here until a new
            // start clears the summary and latches a fresh golden table.
            if (start) begin
               vec_d   = '0;
               wait_d  = '0;
               table_d = '0;
               err_d   = '0;
               fseen_d = 1'b0;
               ffail_d = '0;
               match_d = 1'b0;
               exp_d   = expected;
               busy_d  = 1'b1;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // Together with the SAMPLE cycle this holds each vector for
            // SETTLE+1 cycles before moving on.
            wait_d = wait_q + 1'b1;
            if (wait_q == WAIT_LAST) begin
               state_d = ST_SAMPLE;
            end
         end

         ST_SAMPLE: begin
            table_d[vec_q] = f_in;
            if (sample_mismatch) begin
               err_d = err_q + 1'b1;
               if (!fseen_q) begin
                  fseen_d = 1'b1;
                  ffail_d = vec_q;
               end
            end

            if (vec_q == VEC_LAST) begin
               // busy drops and match is resolved on the edge into FINISH so
               // both are already valid in the cycle done is asserted. The
               // vector stays at its final value rather than wrapping.
               busy_d  = 1'b0;
               match_d = (err_d == '0);
               state_d = ST_FINISH;
            end else begin
               vec_d   = vec_q + 1'b1;
               wait_d  = '0;
               state_d = ST_WAIT;
            end
         end

         ST_FINISH: begin
            // start seen here is ignored; a held start is picked up in IDLE
            // on the next edge, giving back-to-back runs.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign vec_out     = vec_q;
   assign busy        = busy_q;
   assign done        = (state_q == ST_FINISH);
   assign table_out   = table_q;
   assign err_count   = err_q;
   assign match       = match_q;
   assign first_fail  = ffail_q;
   assign fail_seen   = fseen_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Drives the sequencer with a table-described function block (f_in is looked
// up from fn_tab using vec_out) and compares every run against a reference
// computed directly from the tables: captured table = function table, error
// count = popcount of the difference, first failure = lowest differing index.
// Timing expectations come from the vector count and the per-vector hold.
// -----------------------------------------------------------------------------
module tb_truth_table_sequencer;

   localparam int N_IN   = 4;
   localparam int SETTLE = 2;
   localparam int NVEC   = 1 << N_IN;
   localparam int HOLD   = SETTLE + 1;
   localparam int RUN    = NVEC * HOLD;   // 48 cycles with the defaults

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [NVEC-1:0]   expected;
   logic              f_in;
   logic [N_IN-1:0]   vec_out;
   logic              busy;
   logic              done;
   logic [NVEC-1:0]   table_out;
   logic [N_IN:0]     err_count;
   logic              match;
   logic [N_IN-1:0]   first_fail;
   logic              fail_seen;
   logic [1:0]        state_dbg_o;

   always #5 clk = ~clk;

   truth_table_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .expected    (expected),
      .f_in        (f_in),
      .vec_out     (vec_out),
      .busy        (busy),
      .done        (done),
      .table_out   (table_out),
      .err_count   (err_count),
      .match       (match),
      .first_fail  (first_fail),
      .fail_seen   (fail_seen),
      .state_dbg_o (state_dbg_o)
   );

   // Function block under sequence: a plain truth-table lookup.
   logic [NVEC-1:0] fn_tab;
   always_comb f_in = fn_tab[vec_out];

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   logic [N_IN-1:0] vec_log[$];
   logic [N_IN-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver: one run. Start is accepted on edge 0; the loop then looks at the
   // cycle after each edge e. restart_edge (>0) raises start across that edge.
   // The golden input is scrambled after acceptance: only the latched copy may
   // matter.
   // ---------------------------------------------------------------------------
   task automatic run_once(input int restart_edge, output int done_edge, output int busy_cycles);
      vec_log.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      expected = 16'($urandom);
      done_edge   = -1;
      busy_cycles = 0;
      for (int e = 0; e < 4 * RUN; e++) begin
         start = (e + 1 == restart_edge) ? 1'b1 : 1'b0;
         if (busy) begin
            busy_cycles++;
            vec_log.push_back(vec_out);
         end
         if (done) begin
            done_edge = e;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   // Reference model: everything follows from the two tables.
   task automatic verify(input string pfx, input logic [NVEC-1:0] ftab,
                         input logic [NVEC-1:0] gold, input int done_edge,
                         input int busy_cycles);
      logic [NVEC-1:0] diff;
      int              n_err;
      int              ff;
      int              bad;
      diff  = ftab ^ gold;
      n_err = $countones(diff);
      ff    = 0;
      for (int i = NVEC - 1; i >= 0; i--) if (diff[i]) ff = i;

      check({pfx, "_done_edge"}, done_edge, RUN);
      check({pfx, "_busy_cycles"}, busy_cycles, RUN);
      check({pfx, "_table"}, table_out, ftab);
      check({pfx, "_err_count"}, err_count, n_err);
      check({pfx, "_match"}, match, (n_err == 0));
      check({pfx, "_first_fail"}, first_fail, ff);
      check({pfx, "_fail_seen"}, fail_seen, (n_err != 0));
      check({pfx, "_vec_final"}, vec_out, NVEC - 1);

      // Vector order: each index appears HOLD times in ascending order.
      exp_q.delete();
      for (int v = 0; v < NVEC; v++)
         for (int h = 0; h < HOLD; h++) exp_q.push_back(N_IN'(v));
      bad = (vec_log.size() == exp_q.size()) ? 0 : 1;
      if (bad == 0)
         for (int k = 0; k < exp_q.size(); k++) if (vec_log[k] !== exp_q[k]) bad++;
      check({pfx, "_vec_sequence"}, bad, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed + randomized sequence
   // ---------------------------------------------------------------------------
   initial begin
      int de, bc, n_done;
      logic [NVEC-1:0] par_tab, and_tab, gold, mask;
      int done_at[$];

      rst      = 1'b1;
      start    = 1'b0;
      expected = '0;
      fn_tab   = '0;

      // Parity and AND4 tables from their definitions.
      for (int i = 0; i < NVEC; i++) begin
         par_tab[i] = ($countones(i) % 2) == 1;
         and_tab[i] = (i == NVEC - 1);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", state_dbg_o, 0);
      check("rst_outs", {vec_out, busy, done, table_out, err_count, match, first_fail, fail_seen}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_start", {busy, done, state_dbg_o}, 0);

      // 1. Parity, golden 16'h6996.
      fn_tab   = par_tab;
      expected = 16'h6996;
      run_once(-1, de, bc);
      verify("parity", par_tab, 16'h6996, de, bc);
      check("parity_gold_const", par_tab, 16'h6996);
      check("vec_1010_abcd", {vec_log[10*HOLD][3], vec_log[10*HOLD][2],
                              vec_log[10*HOLD][1], vec_log[10*HOLD][0]}, 4'b1010);
      @(negedge clk);
      check("done_one_cycle", {done, busy}, 0);
      repeat (3) @(negedge clk);
      check("hold_after_finish", {table_out, match, vec_out}, {16'h6996, 1'b1, 4'hF});

      // 2. AND4 matching, then with one wrong golden bit.
      fn_tab   = and_tab;
      expected = 16'h8000;
      run_once(-1, de, bc);
      verify("and4_pass", and_tab, 16'h8000, de, bc);
      expected = 16'h8001;
      run_once(-1, de, bc);
      verify("and4_fail", and_tab, 16'h8001, de, bc);

      // 3. Stuck-at-0 block against an all-ones golden table.
      fn_tab   = '0;
      expected = 16'hFFFF;
      run_once(-1, de, bc);
      verify("stuck0", 16'h0000, 16'hFFFF, de, bc);

      // 5. Restart attempt at edge 10 is ignored; exactly one done.
      fn_tab   = par_tab;
      expected = par_tab;
      run_once(10, de, bc);
      verify("restart", par_tab, par_tab, de, bc);
      n_done = 0;
      for (int k = 0; k < RUN + 10; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("restart_extra_done", n_done, 0);

      // 6. Reset at edge 20 mid-run, then a clean full run.
      fn_tab   = 16'($urandom);
      expected = fn_tab;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_state", state_dbg_o, 0);
      check("midrst_outs", {vec_out, busy, done, table_out, err_count, match, first_fail, fail_seen}, 0);
      rst = 1'b0;
      gold = fn_tab;
      expected = gold;
      run_once(-1, de, bc);
      verify("after_rst", fn_tab, gold, de, bc);

      // Back-to-back runs with start held high: done after edges 48 and 98.
      done_at.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int e = 0; e < 2 * RUN + 14; e++) begin
         @(negedge clk);
         if (e == RUN + 3) start = 1'b0;
         if (done) done_at.push_back(e);
      end
      check("b2b_done_count", done_at.size(), 2);
      if (done_at.size() == 2) begin
         check("b2b_done1", done_at[0], RUN);
         check("b2b_done2", done_at[1], 2 * RUN + 2);
      end

      // Randomized function tables with sparse golden corruptions.
      for (int r = 0; r < 4; r++) begin
         fn_tab = 16'($urandom);
         mask   = (r == 0) ? '0 : 16'($urandom & $urandom & $urandom);
         gold   = fn_tab ^ mask;
         expected = gold;
         run_once(-1, de, bc);
         verify($sformatf("rand%0d", r), fn_tab, gold, de, bc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
